arb_4req_sched: RTL and testbench

- Sequential 4-requester arbiter that shares a single resource among four clients, using the same priority order as the team's 4x2 priority encoder (req[3] highest).
- Registers a one-hot grant plus an encoded grant ID with a valid flag.
- Holds the grant until the owner releases or a hold timeout expires.
- Sits between client request lines and the shared datapath mux select.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_prio_pick.sv | 24 ++
 rtl/arb_4req_sched.sv | 122 ++++++++++++
 tb/tb_arb_4req_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the 4-requester arbiter.
// State encodings, sizes and a one-hot helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] id2onehot(
        input logic [ID_W-1:0] id
    );
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Priority picker: searches downward from base (mod 4).
// The first requesting index in that order wins.
module arb_prio_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    base,
    output logic [ID_W-1:0]    pick_id,
    output logic               any_req
);

    // Lowest priority written first, so the base index wins last.
    always_comb begin
        pick_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[base - ID_W'(i)]) begin
                pick_id = base - ID_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/arb_4req_sched.sv
// 4-requester arbiter with grant hold and hold timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed 3>2>1>0.
module arb_4req_sched
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;

    logic [ID_W-1:0]    base;
    logic [ID_W-1:0]    pick_id;
    logic               any_req;
    logic               hold_lim;
    logic               owner_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign base = last_id_q - ID_W'(1);
`else
    logic unused_last_id;
    assign base = ID_W'(NUM_REQ - 1);
    assign unused_last_id = ^last_id_q;
`endif

    arb_prio_pick u_pick (
        .req     (req),
        .base    (base),
        .pick_id (pick_id),
        .any_req (any_req)
    );

    assign owner_req = req[gnt_id_q];
    assign hold_lim  = (MAX_HOLD != 0) &&
                       (hold_cnt_q == CNT_W'(MAX_HOLD));

    // Next-state: arbitrate in IDLE, hold or release in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_GRANT;
                    gnt_d       = id2onehot(pick_id);
                    gnt_id_d    = pick_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    last_id_d   = pick_id;
                end else begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (done || !owner_req || hold_lim) begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // Only a revocation of a still-requesting owner pulses.
                    timeout_d   = !done && owner_req && hold_lim;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb_4req_sched.sv
// Directed bench for arb_4req_sched (MAX_HOLD=16).
// Expected ids follow the build selected by ARB_ROUND_ROBIN_EN.
module tb_arb_4req_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk;
    int n_fail;

    arb_4req_sched #(
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       vld;
        logic [1:0] id_fix;
        logic [1:0] id_rr;
        logic       tmo;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(
        input logic       r,
        input logic [3:0] q,
        input logic       d,
        input logic       v,
        input logic [1:0] idf,
        input logic [1:0] idr,
        input logic       t
    );
        vec_t x;
        x.rst    = r;
        x.req    = q;
        x.done   = d;
        x.vld    = v;
        x.id_fix = idf;
        x.id_rr  = idr;
        x.tmo    = t;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q,
                        input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [1:0] id, input logic t);
        logic [3:0] eg;
        eg = v ? (4'b0001 << id) : 4'b0000;
        chk({nm, ".gnt"},       32'(gnt),       32'(eg));
        chk({nm, ".gnt_id"},    32'(gnt_id),    v ? 32'(id) : 32'd0);
        chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        chk({nm, ".timeout"},   32'(timeout),   32'(t));
        chk({nm, ".onehot"},    32'($countones(gnt) <= 1), 32'd1);
        chk({nm, ".gnt_vs_vld"}, 32'(gnt != 4'b0), 32'(gnt_valid));
    endtask

    logic [1:0] eid;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 4'b0;
        done   = 1'b0;

        tbl[0]  = mk(1, 4'b0101, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 4'b0101, 0, 1, 2, 2, 0);
        tbl[2]  = mk(0, 4'b0101, 0, 1, 2, 2, 0);
        tbl[3]  = mk(0, 4'b0001, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 4'b0001, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 4'b0001, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 4'b0000, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 4'b0000, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[9]  = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[10] = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[11] = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[12] = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[13] = mk(0, 4'b1111, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 4'b1111, 0, 1, 3, 2, 0);
        tbl[15] = mk(0, 4'b1111, 1, 0, 0, 0, 0);
        tbl[16] = mk(0, 4'b1111, 0, 1, 3, 1, 0);
        tbl[17] = mk(0, 4'b1111, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 4'b1111, 0, 1, 3, 0, 0);
        tbl[19] = mk(0, 4'b1111, 1, 0, 0, 0, 0);
        tbl[20] = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[21] = mk(0, 4'b1111, 1, 0, 0, 0, 0);
        tbl[22] = mk(0, 4'b0010, 0, 1, 1, 1, 0);
        tbl[23] = mk(1, 4'b0010, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 4'b1111, 0, 1, 3, 3, 0);
        tbl[25] = mk(1, 4'b0000, 0, 0, 0, 0, 0);

        step(1'b1, 4'b0000, 1'b0);
        chk_out("reset", 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 26; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            eid = tbl[i].id_rr;
`else
            eid = tbl[i].id_fix;
`endif
            step(tbl[i].rst, tbl[i].req, tbl[i].done);
            chk_out($sformatf("vec%0d", i), tbl[i].vld, eid,
                    tbl[i].tmo);
        end

        // Timeout: client 1 holds for 16 cycles then is revoked.
        for (int c = 1; c <= 16; c++) begin
            step(1'b0, 4'b0010, 1'b0);
            chk_out($sformatf("tmo_hold%0d", c), 1'b1, 2'd1, 1'b0);
        end
        step(1'b0, 4'b0010, 1'b0);
        chk_out("tmo_pulse", 1'b0, 2'd0, 1'b1);
        step(1'b0, 4'b0010, 1'b0);
        chk_out("tmo_regrant", 1'b1, 2'd1, 1'b0);

        // done on the 16th grant cycle beats the timeout.
        for (int c = 2; c <= 16; c++) begin
            step(1'b0, 4'b0010, 1'b0);
            chk_out($sformatf("dt_hold%0d", c), 1'b1, 2'd1, 1'b0);
        end
        step(1'b0, 4'b0010, 1'b1);
        chk_out("dt_release", 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk_out("dt_idle", 1'b0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
